// File: rtl/mcs4.sv
// Shared MCS-4 types: instruction sub-cycles, data-bus nibble, PC commands and
// the constants used by the program-address logic.
package mcs4;

  typedef enum logic [2:0] {
    A1, A2, A3, M1, M2, X1, X2, X3
  } instr_cyc_t;

  typedef logic [3:0] char_t;

  // Encodings 6 and 7 are undefined and are executed as PC_INC.
  typedef enum logic [2:0] {
    PC_INC  = 3'd0,
    PC_JUMP = 3'd1,
    PC_PAGE = 3'd2,
    PC_CALL = 3'd3,
    PC_RET  = 3'd4,
    PC_HOLD = 3'd5
  } pc_cmd_t;

  localparam int Stack_depth_max = 16;
  localparam int Page_bits       = 8;

endpackage

// File: rtl/i4040_addr_stack_if.sv
// Bus between the instruction sequencer (master) and the program-address
// block (slave).
interface i4040_addr_stack_if #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8
);
  import mcs4::*;

  localparam int LVL_W = $clog2(DEPTH) + 1;

  instr_cyc_t        icyc;
  pc_cmd_t           cmd;
  logic [ADDR_W-1:0] tgt_addr;
  logic              clr_flags;
  logic [ADDR_W-1:0] pc;
  char_t             addr_nib;
  logic              end_of_page;
  logic [LVL_W-1:0]  stack_lvl;
  logic              stack_ovf;
  logic              stack_unf;

  modport master (
    output icyc, cmd, tgt_addr, clr_flags,
    input  pc, addr_nib, end_of_page, stack_lvl, stack_ovf, stack_unf
  );

  modport slave (
    input  icyc, cmd, tgt_addr, clr_flags,
    output pc, addr_nib, end_of_page, stack_lvl, stack_ovf, stack_unf
  );

endinterface

// File: rtl/i4040_ret_stack.sv
// Circular return-address store: a full stack overwrites its oldest entry and
// an empty stack still pops the wrapped slot; both cases raise sticky flags.
module i4040_ret_stack #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              clr_flags,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] pop_data,
  output logic [LVL_W-1:0]  stack_lvl,
  output logic              stack_ovf,
  output logic              stack_unf
);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wp;
  logic              full;
  logic              empty;

  assign full     = (stack_lvl == LVL_W'(DEPTH));
  assign empty    = (stack_lvl == '0);
  assign pop_data = mem[wp - 1'b1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp        <= '0;
      stack_lvl <= '0;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
      // NOTE: the store is small and its reset contents are architecturally
      // visible (a pop from an empty stack returns a slot), so it is cleared.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wp] <= push_data;
        wp      <= wp + 1'b1;
        if (!full) stack_lvl <= stack_lvl + 1'b1;
      end else if (pop) begin
        wp <= wp - 1'b1;
        if (!empty) stack_lvl <= stack_lvl - 1'b1;
      end
      // A flag-setting event in the same cycle as clr_flags keeps the flag set.
      stack_ovf <= (push && full)  || (stack_ovf && !clr_flags);
      stack_unf <= (pop  && empty) || (stack_unf && !clr_flags);
    end
  end

endmodule

// File: rtl/i4040_addr_stack.sv
// Program counter for the 4040 core: command captured at X2, applied at X3,
// plus the address-nibble mux driven onto the data bus during A1..A3.
module i4040_addr_stack
  import mcs4::*;
#(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8
) (
  input logic                clk,
  input logic                rst_n,
  i4040_addr_stack_if.slave  bus
);

  if (ADDR_W != 8 && ADDR_W != 12) begin : g_bad_addr_w
    $error("i4040_addr_stack: ADDR_W must be 8 or 12");
  end
  if (DEPTH < 2 || DEPTH > Stack_depth_max || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("i4040_addr_stack: DEPTH must be a power of two in 2..16");
  end

  pc_cmd_t           cmd_q;
  logic [ADDR_W-1:0] tgt_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] inc;
  logic [ADDR_W-1:0] page_addr;
  logic [ADDR_W-1:0] ret_addr;
  logic [11:0]       pc_ext;
  logic              push;
  logic              pop;
  char_t             nib;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_q <= PC_HOLD;
      tgt_q <= '0;
    end else if (bus.icyc == X2) begin
      cmd_q <= bus.cmd;
      tgt_q <= bus.tgt_addr;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    inc       = pc_q + 1'b1;
    page_addr = inc;
    page_addr[Page_bits-1:0] = tgt_q[Page_bits-1:0];
    pc_next   = pc_q;
    push      = 1'b0;
    pop       = 1'b0;
    if (bus.icyc == X3) begin
      case (cmd_q)
        PC_INC:  pc_next = inc;
        PC_JUMP: pc_next = tgt_q;
        PC_PAGE: pc_next = page_addr;
        PC_CALL: begin
          pc_next = tgt_q;
          push    = 1'b1;
        end
        PC_RET: begin
          pc_next = ret_addr;
          pop     = 1'b1;
        end
        PC_HOLD: pc_next = pc_q;
        default: pc_next = inc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pc_q <= '0;
    else        pc_q <= pc_next;
  end

  i4040_ret_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .pop       (pop),
    .clr_flags (bus.clr_flags),
    .push_data (inc),
    .pop_data  (ret_addr),
    .stack_lvl (bus.stack_lvl),
    .stack_ovf (bus.stack_ovf),
    .stack_unf (bus.stack_unf)
  );

  // Zero-extending to 12 bits makes the A3 nibble read 0 in the 8-bit build.
  assign pc_ext = 12'(pc_q);

  always_comb begin
    nib = 4'h0;
    case (bus.icyc)
      A1:      nib = pc_ext[3:0];
      A2:      nib = pc_ext[7:4];
      A3:      nib = pc_ext[11:8];
      default: nib = 4'h0;
    endcase
  end

  assign bus.pc          = pc_q;
  assign bus.addr_nib    = nib;
  assign bus.end_of_page = &pc_q[7:0];

endmodule

// File: tb/tb_i4040_addr_stack.sv
// Directed bench for i4040_addr_stack: a 12-bit/8-deep instance plus an 8-bit
// instance sharing the same sub-cycle and command stream.
module tb_i4040_addr_stack;
  import mcs4::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  char_t nib_a1, nib_a2, nib_a3, nib8_a3;

  i4040_addr_stack_if #(.ADDR_W(12), .DEPTH(8)) bus  ();
  i4040_addr_stack_if #(.ADDR_W(8),  .DEPTH(8)) bus8 ();

  assign bus8.icyc      = bus.icyc;
  assign bus8.cmd       = bus.cmd;
  assign bus8.tgt_addr  = bus.tgt_addr[7:0];
  assign bus8.clr_flags = bus.clr_flags;

  i4040_addr_stack #(.ADDR_W(12), .DEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  i4040_addr_stack #(.ADDR_W(8), .DEPTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input instr_cyc_t c, input pc_cmd_t k, input logic [11:0] t,
                      input logic clr);
    @(negedge clk);
    bus.icyc      = c;
    bus.cmd       = k;
    bus.tgt_addr  = t;
    bus.clr_flags = clr;
    @(posedge clk);
    #1;
  endtask

  // One instruction cycle; cmd/tgt are only meaningful at X2, the other
  // sub-cycles carry decoy commands that must be ignored.
  task automatic instr(input pc_cmd_t k, input logic [11:0] t, input logic clr);
    step(A1, PC_JUMP, 12'hABC, 1'b0); nib_a1 = bus.addr_nib;
    step(A2, PC_JUMP, 12'hABC, 1'b0); nib_a2 = bus.addr_nib;
    step(A3, PC_JUMP, 12'hABC, 1'b0); nib_a3 = bus.addr_nib; nib8_a3 = bus8.addr_nib;
    step(M1, PC_RET,  12'hABC, 1'b0);
    step(M2, PC_CALL, 12'hABC, 1'b0);
    step(X1, PC_JUMP, 12'hABC, 1'b0);
    step(X2, k, t, 1'b0);
    step(X3, PC_CALL, 12'h777, clr);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step(A1, PC_JUMP, 12'h5A5, 1'b0);
    n_tests++;
    if (bus.pc !== 12'h000) begin n_fail++; $display("FAIL reset_pc: got %h want 000", bus.pc); end
    n_tests++;
    if (bus.stack_lvl !== 4'd0) begin n_fail++; $display("FAIL reset_lvl: got %0d want 0", bus.stack_lvl); end
    n_tests++;
    if ({bus.stack_ovf, bus.stack_unf} !== 2'b00) begin
      n_fail++; $display("FAIL reset_flags: got %b want 00", {bus.stack_ovf, bus.stack_unf});
    end
    n_tests++;
    if (bus.addr_nib !== 4'h0) begin n_fail++; $display("FAIL reset_nib: got %h want 0", bus.addr_nib); end
    n_tests++;
    if (bus8.pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc8: got %h want 00", bus8.pc); end
    rst_n = 1'b1;
  endtask

  task automatic test_inc();
    for (int i = 0; i < 20; i++) instr(PC_INC, 12'h000, 1'b0);
    n_tests++;
    if (bus.pc !== 12'h014) begin n_fail++; $display("FAIL inc20_pc: got %h want 014", bus.pc); end
    n_tests++;
    if (bus8.pc !== 8'h14) begin n_fail++; $display("FAIL inc20_pc8: got %h want 14", bus8.pc); end
    instr(PC_HOLD, 12'h000, 1'b0);
    n_tests++;
    if ({nib_a1, nib_a2, nib_a3} !== 12'h410) begin
      n_fail++; $display("FAIL inc20_nibs: got %h%h%h want 410", nib_a1, nib_a2, nib_a3);
    end
    n_tests++;
    if (bus.pc !== 12'h014) begin n_fail++; $display("FAIL hold_pc: got %h want 014", bus.pc); end
  endtask

  task automatic test_page();
    instr(PC_JUMP, 12'h3FE, 1'b0);
    n_tests++;
    if ({bus.pc, bus.end_of_page} !== {12'h3FE, 1'b0}) begin
      n_fail++; $display("FAIL jump_3fe: got pc %h eop %b want 3fe 0", bus.pc, bus.end_of_page);
    end
    instr(PC_PAGE, 12'h055, 1'b0);
    n_tests++;
    if (bus.pc !== 12'h355) begin n_fail++; $display("FAIL page_same: got %h want 355", bus.pc); end
    instr(PC_JUMP, 12'h3FF, 1'b0);
    n_tests++;
    if (bus.end_of_page !== 1'b1) begin n_fail++; $display("FAIL eop_3ff: got %b want 1", bus.end_of_page); end
    instr(PC_PAGE, 12'h055, 1'b0);
    n_tests++;
    if (bus.pc !== 12'h455) begin n_fail++; $display("FAIL page_next: got %h want 455", bus.pc); end
    n_tests++;
    if (bus8.pc !== 8'h55) begin n_fail++; $display("FAIL page_pc8: got %h want 55", bus8.pc); end
  endtask

  task automatic test_wrap();
    instr(PC_JUMP, 12'hFFF, 1'b0);
    n_tests++;
    if ({bus.pc, bus8.pc, bus8.end_of_page} !== {12'hFFF, 8'hFF, 1'b1}) begin
      n_fail++; $display("FAIL wrap_setup: got %h %h eop8 %b want fff ff 1", bus.pc, bus8.pc, bus8.end_of_page);
    end
    instr(PC_INC, 12'h000, 1'b0);
    n_tests++;
    if ({nib_a3, nib8_a3} !== 8'hF0) begin
      n_fail++; $display("FAIL wrap_a3: got %h/%h want f/0", nib_a3, nib8_a3);
    end
    n_tests++;
    if ({bus.pc, bus8.pc} !== {12'h000, 8'h00}) begin
      n_fail++; $display("FAIL wrap_pc: got %h %h want 000 00", bus.pc, bus8.pc);
    end
    n_tests++;
    if ({bus.stack_ovf, bus.stack_unf, bus8.stack_ovf, bus8.stack_unf, bus.stack_lvl} !== 8'h00) begin
      n_fail++; $display("FAIL wrap_flags: got %b%b%b%b lvl %0d want 0000 lvl 0",
                         bus.stack_ovf, bus.stack_unf, bus8.stack_ovf, bus8.stack_unf, bus.stack_lvl);
    end
  endtask

  task automatic test_call_ovf();
    instr(PC_JUMP, 12'h010, 1'b0);
    for (int k = 1; k <= 8; k++) instr(PC_CALL, 12'h0FF + 12'(k), 1'b0);
    n_tests++;
    if ({bus.stack_lvl, bus.stack_ovf} !== {4'd8, 1'b0}) begin
      n_fail++; $display("FAIL call8: got lvl %0d ovf %b want 8 0", bus.stack_lvl, bus.stack_ovf);
    end
    instr(PC_CALL, 12'h108, 1'b0);
    n_tests++;
    if ({bus.stack_lvl, bus.stack_ovf, bus.pc} !== {4'd8, 1'b1, 12'h108}) begin
      n_fail++; $display("FAIL call9: got lvl %0d ovf %b pc %h want 8 1 108", bus.stack_lvl, bus.stack_ovf, bus.pc);
    end
    // Newest first: 0x108 (overwrote 0x011), then 0x107 down to 0x101.
    for (int j = 1; j <= 8; j++) begin
      instr(PC_RET, 12'h000, 1'b0);
      n_tests++;
      if (bus.pc !== 12'h109 - 12'(j)) begin
        n_fail++; $display("FAIL ret%0d: got %h want %h", j, bus.pc, 12'h109 - 12'(j));
      end
    end
    n_tests++;
    if ({bus.stack_lvl, bus.stack_unf, bus.stack_ovf} !== {4'd0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL ret_end: got lvl %0d unf %b ovf %b want 0 0 1", bus.stack_lvl, bus.stack_unf, bus.stack_ovf);
    end
  endtask

  task automatic test_underflow();
    instr(PC_HOLD, 12'h000, 1'b1);
    n_tests++;
    if (bus.stack_ovf !== 1'b0) begin n_fail++; $display("FAIL clr_ovf: got %b want 0", bus.stack_ovf); end
    instr(PC_RET, 12'h000, 1'b0);
    n_tests++;
    if ({bus.stack_unf, bus.stack_lvl, bus.pc} !== {1'b1, 4'd0, 12'h108}) begin
      n_fail++; $display("FAIL unf1: got unf %b lvl %0d pc %h want 1 0 108", bus.stack_unf, bus.stack_lvl, bus.pc);
    end
    instr(PC_RET, 12'h000, 1'b1);
    n_tests++;
    if ({bus.stack_unf, bus.stack_lvl, bus.pc} !== {1'b1, 4'd0, 12'h107}) begin
      n_fail++; $display("FAIL unf_set_wins: got unf %b lvl %0d pc %h want 1 0 107", bus.stack_unf, bus.stack_lvl, bus.pc);
    end
    instr(PC_HOLD, 12'h000, 1'b1);
    n_tests++;
    if (bus.stack_unf !== 1'b0) begin n_fail++; $display("FAIL clr_unf: got %b want 0", bus.stack_unf); end
  endtask

  task automatic test_undef_cmd();
    instr(pc_cmd_t'(3'd7), 12'h3C3, 1'b0);
    n_tests++;
    if (bus.pc !== 12'h108) begin n_fail++; $display("FAIL undef7: got %h want 108", bus.pc); end
    instr(pc_cmd_t'(3'd6), 12'h3C3, 1'b0);
    n_tests++;
    if (bus.pc !== 12'h109) begin n_fail++; $display("FAIL undef6: got %h want 109", bus.pc); end
  endtask

  task automatic test_reset_abort();
    step(A1, PC_HOLD, 12'h000, 1'b0);
    step(A2, PC_HOLD, 12'h000, 1'b0);
    step(A3, PC_HOLD, 12'h000, 1'b0);
    step(M1, PC_HOLD, 12'h000, 1'b0);
    step(M2, PC_HOLD, 12'h000, 1'b0);
    step(X1, PC_HOLD, 12'h000, 1'b0);
    step(X2, PC_CALL, 12'h2AB, 1'b0);
    @(negedge clk);
    rst_n    = 1'b0;
    bus.icyc = X3;
    @(posedge clk);
    #1;
    n_tests++;
    if ({bus.pc, bus.stack_lvl} !== {12'h000, 4'd0}) begin
      n_fail++; $display("FAIL abort_pc: got pc %h lvl %0d want 000 0", bus.pc, bus.stack_lvl);
    end
    // Another X3 edge out of reset must execute the reset command (hold).
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_tests++;
    if ({bus.pc, bus.stack_lvl} !== {12'h000, 4'd0}) begin
      n_fail++; $display("FAIL abort_discard: got pc %h lvl %0d want 000 0", bus.pc, bus.stack_lvl);
    end
    instr(PC_RET, 12'h000, 1'b0);
    n_tests++;
    if ({bus.pc, bus.stack_unf} !== {12'h000, 1'b1}) begin
      n_fail++; $display("FAIL abort_nopush: got pc %h unf %b want 000 1", bus.pc, bus.stack_unf);
    end
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.icyc      = A1;
    bus.cmd       = PC_HOLD;
    bus.tgt_addr  = '0;
    bus.clr_flags = 1'b0;
    test_reset();
    test_inc();
    test_page();
    test_wrap();
    test_call_ovf();
    test_underflow();
    test_undef_cmd();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
